// File: rtl/twi_pkg.sv
// Shared types and bus patterns for the register-level TWI master.
// Read support is built only when TWI_MASTER_READ_EN is defined.
package twi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_RSTART,
    ST_RBYTE,
    ST_STOP,
    ST_DONE
  } twi_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // {sda,scl} per quarter, q0 in the top pair
  localparam logic [7:0] START_PAT  = 8'b11_11_01_00;
  localparam logic [7:0] RSTART_PAT = 8'b10_11_01_00;
  localparam logic [7:0] STOP_PAT   = 8'b00_01_11_11;

  localparam int BITS_PER_BYTE = 8;
  localparam int WR_QUARTERS   = 116;
  localparam int RD_QUARTERS   = 156;

  function automatic logic [1:0] pat_sel(
    logic [7:0] p,
    logic [1:0] q
  );
    logic [1:0] r;
    case (q)
      Q0:      r = p[7:6];
      Q1:      r = p[5:4];
      Q2:      r = p[3:2];
      default: r = p[1:0];
    endcase
    return r;
  endfunction

  function automatic logic [1:0] bus_pat(
    twi_state_t s,
    logic [1:0] q,
    logic       b
  );
    logic       scl_hi;
    logic [1:0] r;
    scl_hi = (q == Q1) || (q == Q2);
    case (s)
      ST_START:  r = pat_sel(START_PAT, q);
      ST_RSTART: r = pat_sel(RSTART_PAT, q);
      ST_STOP:   r = pat_sel(STOP_PAT, q);
      ST_BYTE:   r = {b, scl_hi};
      ST_ACK,
      ST_RBYTE:  r = {1'b1, scl_hi};
      default:   r = 2'b11;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/twi_reg_master_tick.sv
// Quarter-period divider: o_tick high on the last cycle of each
// SCL quarter; i_clr restarts the quarter at a new transaction.
module twi_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/twi_reg_master.sv
// Register-level TWI master for peripheral bring-up over open-drain pads.
// Define TWI_MASTER_READ_EN to enable the register read sequence.
module twi_reg_master
  import twi_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rnw,
  input  logic [6:0] i_req_dev_addr,
  input  logic [7:0] i_req_reg_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic       o_rsp_nack,
  output logic [7:0] o_rsp_rdata,
  input  logic       i_twi_sda,
  output logic       o_twi_sda,
  output logic       o_twi_scl
);

  twi_state_t state;
  logic [1:0] q;
  logic [3:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [7:0] shift;
  logic [6:0] dev;
  logic [7:0] reg_a;
  logic [7:0] wdata;
  logic       rnw;
  logic [1:0] sda_sync;
  logic       sda_s;
  logic       accept;
  logic       tick;

  assign accept = i_req_valid & o_req_ready;
  assign sda_s  = sda_sync[1];

`ifndef TWI_MASTER_READ_EN
  logic unused_rnw;
  assign unused_rnw = i_req_rnw;
`endif

  twi_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (accept),
    .o_tick(tick)
  );

  // Bus pins follow the current symbol one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      q           <= Q0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      shift       <= '0;
      dev         <= '0;
      reg_a       <= '0;
      wdata       <= '0;
      rnw         <= 1'b0;
      sda_sync    <= 2'b11;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_nack  <= 1'b0;
      o_rsp_rdata <= '0;
      o_twi_sda   <= 1'b1;
      o_twi_scl   <= 1'b1;
    end else begin
      sda_sync    <= {sda_sync[0], i_twi_sda};
      {o_twi_sda, o_twi_scl} <= bus_pat(state, q, shift[7]);
      o_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dev         <= i_req_dev_addr;
            reg_a       <= i_req_reg_addr;
            wdata       <= i_req_wdata;
`ifdef TWI_MASTER_READ_EN
            rnw         <= i_req_rnw;
`else
            rnw         <= 1'b0;
`endif
            o_req_ready <= 1'b0;
            o_rsp_nack  <= 1'b0;
            q           <= Q0;
            state       <= ST_START;
          end
        end
        ST_DONE: begin
          o_rsp_valid <= 1'b1;
          o_req_ready <= 1'b1;
          o_rsp_rdata <= rnw ? shift : 8'h00;
          state       <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            q <= q + 2'd1;
            if (q == Q2) begin
              if (state == ST_ACK) begin
                o_rsp_nack <= o_rsp_nack | sda_s;
              end
              if (state == ST_RBYTE &&
                  bit_cnt < 4'(BITS_PER_BYTE)) begin
                shift <= {shift[6:0], sda_s};
              end
            end
            if (q == Q3) begin
              case (state)
                ST_START: begin
                  state    <= ST_BYTE;
                  shift    <= {dev, 1'b0};
                  bit_cnt  <= '0;
                  byte_idx <= 2'd0;
                end
                ST_RSTART: begin
                  state    <= ST_BYTE;
                  shift    <= {dev, 1'b1};
                  bit_cnt  <= '0;
                  byte_idx <= 2'd2;
                end
                ST_BYTE: begin
                  if (bit_cnt == 4'(BITS_PER_BYTE - 1)) begin
                    state <= ST_ACK;
                  end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {shift[6:0], 1'b0};
                  end
                end
                ST_ACK: begin
                  bit_cnt <= '0;
                  if (o_rsp_nack) begin
                    state <= ST_STOP;
                  end else begin
                    case (byte_idx)
                      2'd0: begin
                        state    <= ST_BYTE;
                        shift    <= reg_a;
                        byte_idx <= 2'd1;
                      end
                      2'd1: begin
                        if (rnw) begin
                          state <= ST_RSTART;
                        end else begin
                          state    <= ST_BYTE;
                          shift    <= wdata;
                          byte_idx <= 2'd2;
                        end
                      end
                      default: begin
                        state <= rnw ? ST_RBYTE : ST_STOP;
                      end
                    endcase
                  end
                end
                // Ninth RBYTE symbol is the master NACK
                ST_RBYTE: begin
                  if (bit_cnt == 4'(BITS_PER_BYTE)) begin
                    state <= ST_STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                  end
                end
                ST_STOP: state <= ST_DONE;
                default: state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twi_reg_master.sv
// Directed bench for twi_reg_master with an open-drain slave model.
// Read vectors are included when TWI_MASTER_READ_EN is defined.
module tb_twi_reg_master;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_rdata;
  logic       m_sda;
  logic       m_scl;
  logic       slave_sda;
  logic       sda_bus;

  assign sda_bus = m_sda & slave_sda;

  always #5 clk = ~clk;

  twi_reg_master #(
    .CLK_DIV(CD)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_rnw     (req_rnw),
    .i_req_dev_addr(req_dev),
    .i_req_reg_addr(req_reg),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_nack    (rsp_nack),
    .o_rsp_rdata   (rsp_rdata),
    .i_twi_sda     (sda_bus),
    .o_twi_sda     (m_sda),
    .o_twi_scl     (m_scl)
  );

  typedef struct {
    logic            rnw;
    logic [6:0]      dev;
    logic [7:0]      rg;
    logic [7:0]      wd;
    logic            ack_addr;
    logic [7:0]      rdb;
    int              nb;
    logic [2:0][7:0] bb;
    logic            nack;
    logic [7:0]      rdata;
    int              lat;
    int              starts;
    int              stops;
    int              rises;
  } vec_t;

  int npass = 0;
  int ntotal = 0;

  // slave / monitor state (written only by the monitor process)
  int         nstart = 0;
  int         nstop = 0;
  int         nrise = 0;
  int         viol = 0;
  logic       last_mack = 1'b0;
  logic [7:0] blog[$];

  // slave config (written only by the main process)
  logic       cfg_ack_addr = 1'b1;
  logic [7:0] cfg_rdb = 8'h00;
  logic       chk_en = 1'b1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  initial begin
    logic       prev_scl;
    logic       prev_sda;
    logic [7:0] sh;
    int         run;
    int         bitn;
    logic       first;
    logic       rd_phase;
    logic       pend_rd;
    logic       ack;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    sh = '0;
    run = 100;
    bitn = 0;
    first = 1'b0;
    rd_phase = 1'b0;
    pend_rd = 1'b0;
    slave_sda = 1'b1;
    forever begin
      @(negedge clk);
      if (m_scl != prev_scl) begin
        if (chk_en && run < 2 * CD) viol++;
        run = 1;
      end else begin
        run++;
      end
      if (m_scl && prev_scl && prev_sda && !sda_bus) begin
        nstart++;
        bitn = -1;
        first = 1'b1;
        rd_phase = 1'b0;
        pend_rd = 1'b0;
        slave_sda = 1'b1;
      end else if (m_scl && prev_scl && !prev_sda && sda_bus) begin
        nstop++;
        rd_phase = 1'b0;
        pend_rd = 1'b0;
        slave_sda = 1'b1;
      end else if (m_scl && !prev_scl) begin
        nrise++;
        if (rd_phase && bitn == 8) last_mack = sda_bus;
        else sh = {sh[6:0], sda_bus};
      end else if (!m_scl && prev_scl) begin
        bitn++;
        if (bitn == 8) begin
          if (!rd_phase) begin
            blog.push_back(sh);
            ack = first ? cfg_ack_addr : 1'b1;
            pend_rd = first && sh[0] && ack;
            first = 1'b0;
            slave_sda = ack ? 1'b0 : 1'b1;
          end else begin
            slave_sda = 1'b1;
          end
        end else if (bitn == 9) begin
          bitn = 0;
          slave_sda = 1'b1;
          if (pend_rd) begin
            pend_rd = 1'b0;
            rd_phase = 1'b1;
            slave_sda = cfg_rdb[7];
          end
        end else if (rd_phase && bitn > 0 && bitn < 8) begin
          slave_sda = cfg_rdb[7-bitn];
        end
      end
      prev_scl = m_scl;
      prev_sda = sda_bus;
    end
  end

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drive(input vec_t v);
    req_rnw   = v.rnw;
    req_dev   = v.dev;
    req_reg   = v.rg;
    req_wdata = v.wd;
    req_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int         lat;
    int         s0, p0, r0, b0;
    logic [7:0] got;
    string      t;
    t = $sformatf("v%0d", id);
    cfg_ack_addr = v.ack_addr;
    cfg_rdb = v.rdb;
    s0 = nstart;
    p0 = nstop;
    r0 = nrise;
    b0 = blog.size();
    @(negedge clk);
    chk({t, "_ready_idle"}, req_ready, 1);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({t, "_ready_busy"}, req_ready, 0);
    wait_rsp(lat);
    chk({t, "_latency"}, lat, v.lat);
    chk({t, "_nack"}, rsp_nack, v.nack);
    chk({t, "_rdata"}, rsp_rdata, v.rdata);
    chk({t, "_ready_rsp"}, req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk({t, "_rsp_pulse"}, rsp_valid, 0);
    chk({t, "_rdata_hold"}, rsp_rdata, v.rdata);
    chk({t, "_nbytes"}, blog.size() - b0, v.nb);
    for (int i = 0; i < v.nb; i++) begin
      got = (b0 + i < blog.size()) ? blog[b0+i] : 8'hxx;
      chk($sformatf("%s_byte%0d", t, i), got, v.bb[2-i]);
    end
    chk({t, "_starts"}, nstart - s0, v.starts);
    chk({t, "_stops"}, nstop - p0, v.stops);
    chk({t, "_scl_rises"}, nrise - r0, v.rises);
  endtask

  vec_t vecs[4];

  initial begin
    int   lat;
    int   s0, b0, cnt;
    vec_t a;
    logic [7:0] got;
    logic [7:0] exp6 [6];

    vecs[0] = '{1'b0, 7'h76, 8'h1C, 8'hA5, 1'b1, 8'h00, 3,
                24'hEC1CA5, 1'b0, 8'h00, 465, 1, 1, 28};
    vecs[1] = '{1'b0, 7'h21, 8'h10, 8'h55, 1'b0, 8'h00, 1,
                24'h420000, 1'b1, 8'h00, 177, 1, 1, 10};
`ifdef TWI_MASTER_READ_EN
    vecs[2] = '{1'b1, 7'h76, 8'h00, 8'h00, 1'b1, 8'h3C, 3,
                24'hEC00ED, 1'b0, 8'h3C, 625, 2, 1, 38};
`else
    vecs[2] = '{1'b1, 7'h76, 8'h00, 8'h5A, 1'b1, 8'h3C, 3,
                24'hEC005A, 1'b0, 8'h00, 465, 1, 1, 28};
`endif
    vecs[3] = '{1'b0, 7'h50, 8'hFF, 8'h00, 1'b1, 8'h00, 3,
                24'hA0FF00, 1'b0, 8'h00, 465, 1, 1, 28};

    rst = 1'b1;
    req_valid = 1'b0;
    req_rnw = 1'b0;
    req_dev = '0;
    req_reg = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_nack", rsp_nack, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_sda", m_sda, 1);
    chk("rst_scl", m_scl, 1);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
`ifdef TWI_MASTER_READ_EN
    chk("master_nack_on_read", last_mack, 1);
`endif

    // back-to-back: valid held through the response
    cfg_ack_addr = 1'b1;
    s0 = nstart;
    b0 = blog.size();
    exp6 = '{8'hEC, 8'h1C, 8'hA5, 8'hA0, 8'h33, 8'h81};
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    req_dev = 7'h50;
    req_reg = 8'h33;
    req_wdata = 8'h81;
    chk("b2b_ready_busy", req_ready, 0);
    wait_rsp(lat);
    chk("b2b_lat_a", lat, 465);
    chk("b2b_ready_in_rsp", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_accepted", req_ready, 0);
    wait_rsp(lat);
    chk("b2b_lat_b", lat, 465);
    chk("b2b_nack_b", rsp_nack, 0);
    chk("b2b_starts", nstart - s0, 2);
    chk("b2b_nbytes", blog.size() - b0, 6);
    for (int i = 0; i < 6; i++) begin
      got = (b0 + i < blog.size()) ? blog[b0+i] : 8'hxx;
      chk($sformatf("b2b_byte%0d", i), got, exp6[i]);
    end

    // reset during the second data bit of the address byte
    a = vecs[0];
    cfg_ack_addr = 1'b1;
    @(negedge clk);
    drive(a);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (39) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_sda", m_sda, 1);
    chk("midrst_scl", m_scl, 1);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("midrst_no_rsp", cnt, 0);
    chk_en = 1'b1;
    run_vec(a, 9);

    chk("scl_width_viol", viol, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
